spi_vol_master: RTL

SPI_VOL_MASTER -- requirements
Module: spi_vol_master

---
 rtl/spi_vol_master_pkg.sv | 31 +++
 rtl/spi_tick_gen.sv | 45 ++++
 rtl/spi_vol_master.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/spi_vol_master_pkg.sv
// ============================================================================
// Module      : spi_vol_master_pkg
// Description : Shared definitions for the SPI volume-register master: the
//               controller state encoding, address/pad field widths and the
//               frame-length helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_vol_master_pkg;

  // Controller states; the sequence is always IDLE -> SHIFT -> HOLD -> GAP.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2,
    S_GAP   = 2'd3
  } state_e;

  // Register index width and the zero pad that makes the address a byte.
  localparam int unsigned c_addr_w = 5;
  localparam int unsigned c_pad_w  = 3;

  // Bits per frame: one address byte followed by the data field.
  function automatic int unsigned frame_len(input int unsigned vol_bit);
    return c_pad_w + c_addr_w + vol_bit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_tick_gen.sv
// ============================================================================
// Module      : spi_tick_gen
// Description : Emits a one-cycle tick every CLKDIV clock cycles. The count
//               restarts on request so that the first SCK phase of a frame is
//               exactly CLKDIV cycles long.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_tick_gen #(
  parameter int unsigned CLKDIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam logic [7:0] c_term = 8'(CLKDIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Wrap at the terminal count, otherwise advance by one.
  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (restart_i || (cnt_q == c_term)) begin
      cnt_d = 8'd0;
    end
  end

  // Counter register; a restart behaves like reset so the phase is aligned.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == c_term);

endmodule

`default_nettype wire

// File: rtl/spi_vol_master.sv
// ============================================================================
// Module      : spi_vol_master
// Description : Write-only SPI mode-0 master for a bank of 32 volume
//               registers. Each accepted request sends {3'b000, ADDR} then
//               DATA, MSB first, framed by SS, followed by an SS-high gap.
//               Optional feature macro SPI_VOL_MASTER_READBACK_EN adds the
//               RDATA port, which returns the MISO bits captured during the
//               data field, updated on the DONE cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_vol_master
  import spi_vol_master_pkg::*;
#(
  parameter int unsigned CLKDIV  = 2,
  parameter int unsigned VOL_BIT = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [c_addr_w-1:0] req_addr_i,
  input  logic [VOL_BIT-1:0]  req_data_i,
  output logic                busy_o,
  output logic                done_o,
`ifdef SPI_VOL_MASTER_READBACK_EN
  output logic [VOL_BIT-1:0]  rdata_o,
`endif
  output logic                spi_clk_o,
  output logic                spi_ss_o,
  output logic                spi_mosi_o,
  input  logic                spi_miso_i
);

  localparam int unsigned c_frame_len = frame_len(VOL_BIT);
  localparam int unsigned c_cnt_w     = $clog2(c_frame_len);
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(c_frame_len - 1);

  state_e                   state_q;
  logic [c_frame_len-2:0]   frame_q;    // bits still to send after the current one
  logic [c_cnt_w-1:0]       bit_cnt_q;
  logic                     phase_q;    // 0: SCK low half, 1: SCK high half
  logic                     sck_q;
  logic                     ss_q;
  logic                     mosi_q;
  logic                     done_q;

  logic                     w_handshake;
  logic                     w_tick;
  logic [c_frame_len-1:0]   w_frame_load;

  // Ready is withheld while reset is asserted so nothing is accepted then.
  assign req_ready_o  = (state_q == S_IDLE) && !rst_i;
  assign w_handshake  = req_valid_i && req_ready_o;
  assign w_frame_load = {{c_pad_w{1'b0}}, req_addr_i, req_data_i};

  spi_tick_gen #(
    .CLKDIV (CLKDIV)
  ) u_tick (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .restart_i (w_handshake),
    .tick_o    (w_tick)
  );

  // Frame sequencer: all SPI pins and DONE are driven straight from flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      phase_q   <= 1'b0;
      sck_q     <= 1'b0;
      ss_q      <= 1'b1;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_handshake) begin
            frame_q   <= w_frame_load[c_frame_len-2:0];
            mosi_q    <= w_frame_load[c_frame_len-1];
            bit_cnt_q <= '0;
            phase_q   <= 1'b0;
            sck_q     <= 1'b0;
            ss_q      <= 1'b0;
            state_q   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_tick) begin
            if (!phase_q) begin
              // End of the low half: raise SCK, slave samples MOSI here.
              sck_q   <= 1'b1;
              phase_q <= 1'b1;
            end else begin
              // End of the high half: drop SCK and present the next bit.
              sck_q   <= 1'b0;
              phase_q <= 1'b0;
              if (bit_cnt_q == c_last_bit) begin
                state_q <= S_HOLD;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
                mosi_q    <= frame_q[c_frame_len-2];
                frame_q   <= {frame_q[c_frame_len-3:0], 1'b0};
              end
            end
          end
        end
        S_HOLD: begin
          if (w_tick) begin
            ss_q    <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (w_tick) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;
  assign spi_clk_o  = sck_q;
  assign spi_ss_o   = ss_q;
  assign spi_mosi_o = mosi_q;

`ifdef SPI_VOL_MASTER_READBACK_EN
  logic [VOL_BIT-1:0] rx_q;
  logic [VOL_BIT-1:0] rdata_q;

  // Shift MISO in on every SCK rise; after the last bit the register holds
  // exactly the data field, which is published on the DONE cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_q    <= '0;
      rdata_q <= '0;
    end else begin
      if ((state_q == S_SHIFT) && w_tick && !phase_q) begin
        rx_q <= VOL_BIT'({rx_q, spi_miso_i});
      end
      if ((state_q == S_HOLD) && w_tick) begin
        rdata_q <= rx_q;
      end
    end
  end

  assign rdata_o = rdata_q;
`else
  logic unused_miso;
  assign unused_miso = spi_miso_i;
`endif

endmodule

`default_nettype wire
